// File: rtl/data_selector.sv
// data_selector: 2:1 datapath mux (combinational Res) with registered Ctrl_q and a saturating select-change counter.
// Build macro DATA_SELECTOR_REG_OUT_EN: defined -> Res_q is a 1-cycle registered copy of Res; undefined -> Res_q = Res.
module data_selector #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     S,
   input  logic [WIDTH-1:0]     T,
   input  logic                 Ctrl,
   output logic [WIDTH-1:0]     Res,
   output logic [WIDTH-1:0]     Res_q,
   output logic                 Ctrl_q,
   output logic [CNT_WIDTH-1:0] ToggleCnt
);

   logic                 r_ctrl_q;
   logic                 r_primed;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 w_change;
   logic                 w_sat;

   assign Res = Ctrl ? T : S;

   // A change only counts when the previous edge was also out of reset.
   assign w_change = r_primed && (Ctrl != r_ctrl_q);
   assign w_sat    = &r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ctrl_q <= 1'b0;
         r_primed <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_ctrl_q <= Ctrl;
         r_primed <= 1'b1;
         if (w_change && !w_sat)
            r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign Ctrl_q    = r_ctrl_q;
   assign ToggleCnt = r_cnt;

`ifdef DATA_SELECTOR_REG_OUT_EN
   logic [WIDTH-1:0] r_res_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_res_q <= '0;
      else
         r_res_q <= Res;
   end

   assign Res_q = r_res_q;
`else
   assign Res_q = Res;
`endif

endmodule

// File: tb/tb_data_selector.sv
// Self-checking bench for data_selector: vector table, directed reset/saturation sequences, randomized run vs. history model.
module tb_data_selector;

   logic        clk;
   logic        rst_n;
   logic [31:0] S, T;
   logic        Ctrl;
   logic [31:0] Res, Res_q, Res4, Res_q4;
   logic        Ctrl_q, Ctrl_q4;
   logic [15:0] ToggleCnt;
   logic [3:0]  ToggleCnt4;

   int n_cmp = 0;
   int n_err = 0;

   data_selector u_dut (
      .clk(clk), .rst_n(rst_n), .S(S), .T(T), .Ctrl(Ctrl),
      .Res(Res), .Res_q(Res_q), .Ctrl_q(Ctrl_q), .ToggleCnt(ToggleCnt)
   );

   data_selector #(.WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .S(S), .T(T), .Ctrl(Ctrl),
      .Res(Res4), .Res_q(Res_q4), .Ctrl_q(Ctrl_q4), .ToggleCnt(ToggleCnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: history of Ctrl values sampled at each out-of-reset edge since the last reset edge.
   bit          hist[$];
   logic [31:0] m_resq = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         hist.delete();
         m_resq = '0;
      end else begin
         hist.push_back(Ctrl);
         m_resq = Ctrl ? T : S;
      end
   end

   function automatic int exp_cnt(input int max);
      int n = 0;
      for (int i = 1; i < hist.size(); i++)
         if (hist[i] != hist[i-1]) n++;
      return (n > max) ? max : n;
   endfunction

   function automatic logic exp_ctrlq();
      return (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      logic [31:0] sel;
      sel = Ctrl ? T : S;
      chk("Res", Res, sel);
      chk("Res4", Res4, sel);
`ifdef DATA_SELECTOR_REG_OUT_EN
      chk("Res_q", Res_q, m_resq);
      chk("Res_q4", Res_q4, m_resq);
`else
      chk("Res_q", Res_q, sel);
      chk("Res_q4", Res_q4, sel);
`endif
      chk("Ctrl_q", 32'(Ctrl_q), 32'(exp_ctrlq()));
      chk("Ctrl_q4", 32'(Ctrl_q4), 32'(exp_ctrlq()));
      chk("ToggleCnt", 32'(ToggleCnt), 32'(exp_cnt(65535)));
      chk("ToggleCnt4", 32'(ToggleCnt4), 32'(exp_cnt(15)));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      check_state();
   endtask

   typedef struct {
      logic [31:0] s;
      logic [31:0] t;
      logic        c;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{32'h0000FFFF, 32'h00005555, 1'b0, 32'h0000FFFF};
      vecs[1] = '{32'h0000FFFF, 32'h00005555, 1'b1, 32'h00005555};
      vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
      vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000};
      vecs[4] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 32'hDEADBEEF};
      vecs[5] = '{32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678};
      vecs[6] = '{32'h80000001, 32'h7FFFFFFE, 1'b1, 32'h7FFFFFFE};
      vecs[7] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hA5A5A5A5};

      rst_n = 1'b0;
      S     = '0;
      T     = '0;
      Ctrl  = 1'b0;

      // Combinational path while reset is held.
      for (int i = 0; i < 8; i++) begin
         S    = vecs[i].s;
         T    = vecs[i].t;
         Ctrl = vecs[i].c;
         #1;
         chk($sformatf("vec%0d", i), Res, vecs[i].exp);
      end
      S = 32'h0000FFFF;
      T = 32'h00005555;
      for (int i = 0; i < 4; i++) begin
         Ctrl = ~Ctrl;
         #1;
         chk("rst_toggle_res", Res, Ctrl ? 32'h00005555 : 32'h0000FFFF);
      end

      @(negedge clk);
      Ctrl = 1'b0;
      tick();
      tick();
      chk("cnt_in_reset", 32'(ToggleCnt), 32'd0);

      // Priming edge, then 10 counted toggles.
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         Ctrl = ~Ctrl;
         tick();
      end
      chk("cnt_after_10", 32'(ToggleCnt), 32'd10);
      for (int i = 0; i < 3; i++) tick();
      chk("cnt_hold", 32'(ToggleCnt), 32'd10);
      for (int i = 0; i < 20; i++) begin
         Ctrl = ~Ctrl;
         tick();
      end
      chk("cnt4_sat", 32'(ToggleCnt4), 32'hF);
      chk("cnt_after_30", 32'(ToggleCnt), 32'd30);

      // Mid-run reset from a count of 7.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         Ctrl = ~Ctrl;
         tick();
      end
      chk("cnt_7", 32'(ToggleCnt), 32'd7);
      Ctrl  = 1'b1;
      rst_n = 1'b0;
      tick();
      chk("rst_mid_cnt", 32'(ToggleCnt), 32'd0);
      chk("rst_mid_ctrlq", 32'(Ctrl_q), 32'd0);
      chk("rst_mid_res", Res, 32'h00005555);
`ifdef DATA_SELECTOR_REG_OUT_EN
      chk("rst_mid_resq", Res_q, 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // Output register latency.
      S    = 32'h0000FFFF;
      T    = 32'h00005555;
      Ctrl = 1'b0;
      tick();
      Ctrl = 1'b1;
      #1;
`ifdef DATA_SELECTOR_REG_OUT_EN
      chk("resq_before_edge", Res_q, 32'h0000FFFF);
      tick();
      chk("resq_after_edge", Res_q, 32'h00005555);
`else
      chk("resq_eq_res", Res_q, 32'h00005555);
      tick();
`endif

      // Randomized run, with occasional reset and mid-cycle Ctrl glitches.
      for (int i = 0; i < 1500; i++) begin
         S     = $urandom;
         T     = $urandom;
         Ctrl  = 1'($urandom_range(0, 1));
         rst_n = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 7) == 0) begin
            #1;
            Ctrl = ~Ctrl;
            #1;
            chk("glitch_res", Res, Ctrl ? T : S);
            Ctrl = ~Ctrl;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_selector.md
# data_selector

32-bit two-input data selector used in the CPU datapath wherever one of two operand/result buses is steered onto a shared bus, e.g. ALU operand B, register-write data, and next-PC choice. The primary output is purely combinational so the block adds no latency to the datapath. A clocked side section provides a registered copy of the result and a saturating count of select changes for debug and performance visibility.

## Interface
Parameters:
- WIDTH, 32, data width of S, T, Res and Res_q.
- CNT_WIDTH, 16, width of the select-change counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- S  input  WIDTH  data input selected when Ctrl = 0.
- T  input  WIDTH  data input selected when Ctrl = 1.
- Ctrl  input  1  select.
- Res  output  WIDTH  combinational selected data.
- Res_q  output  WIDTH  registered selected data (see Configuration).
- Ctrl_q  output  1  Ctrl sampled on the last rising edge.
- ToggleCnt  output  CNT_WIDTH  number of sampled Ctrl changes since reset, saturating.

## Operation
- Res = T when Ctrl = 1, otherwise Res = S. Purely combinational, bit-for-bit copy, no arithmetic. It is independent of clk and rst_n, and is valid while reset is asserted.
- Ctrl_q: register loaded with Ctrl every rising edge.
- ToggleCnt:
  - increments by 1 on a rising edge when Ctrl != Ctrl_q.
  - saturates at 2^CNT_WIDTH-1 (0xFFFF by default), with no wrap-around.
  - it does not count the first edge after reset release. A change is only counted when the previous edge was also out of reset.
- Res_q follows the selection rule of Res (see Configuration).
- Glitches on Ctrl between clock edges affect Res only. The counter sees only values sampled at edges.

## Timing
- Res: zero-cycle combinational path from S, T and Ctrl.
- Reset, synchronous: on a rising edge with rst_n = 0:
  - Ctrl_q <= 0
  - ToggleCnt <= 0
  - registered Res_q <= 0
  - an internal "primed" flag <= 0
- First edge with rst_n = 1: sets primed = 1 and samples Ctrl. No count is made on this edge.
- Reset asserted mid-operation: all state clears on that edge and the count restarts from 0. Res is unaffected.
- Simultaneous Ctrl change and saturation: the counter holds at its maximum.
- Ctrl_q and ToggleCnt update together on the same edge. ToggleCnt reflects a change one cycle after Ctrl changes.

## Configuration
- Macro: DATA_SELECTOR_REG_OUT_EN.
- Defined:
  - Res_q is a WIDTH-bit register loaded with the selection result each rising edge, giving 1-cycle latency.
  - Res_q resets to 0.
- Undefined:
  - Res_q is wired directly to Res, combinational with zero latency.
  - No output register is instantiated, and reset has no effect on Res_q.
- Res, Ctrl_q and ToggleCnt behave identically in both builds.

## Test plan
- S=0x0000FFFF, T=0x00005555, Ctrl=0 -> Res=0x0000FFFF; set Ctrl=1 -> Res=0x00005555 in the same delta, with no clock required.
- Ctrl toggled every 5 ns with no clock and rst_n low -> Res alternates 0x0000FFFF/0x00005555 with each Ctrl value.
- Reset held 2 cycles, then Ctrl toggled every clock for 10 cycles -> ToggleCnt=0 during reset, then reaches 9 or 10 per the no-count-on-first-edge rule, e.g. 10 toggles after the priming edge gives 10.
- With DATA_SELECTOR_REG_OUT_EN defined: Ctrl 0->1 before edge N -> Res_q=0x00005555 after edge N and 0x0000FFFF before it. Without the macro: Res_q == Res at all times.
- CNT_WIDTH=4, Ctrl toggled for 20 edges -> ToggleCnt stops at 0xF and holds.
- rst_n driven low for one edge mid-run with ToggleCnt=7 -> ToggleCnt=0, Ctrl_q=0, and Res_q=0 (registered build) after that edge, while Res still tracks S/T.
